// File: rtl/branch_resolver.sv
// branch_resolver
//   Execute-stage companion of the branch predictor. Predictions issued at
//   fetch are queued in order; each resolving instruction pops the oldest one
//   and is compared with the real outcome. The result drives the BHT/BTB
//   update and invalidate strobes, the front-end redirect on a misprediction,
//   and a saturating misprediction counter.
//
// Ports
//   s_clk_i, s_resetn_i        clock, asynchronous active-low reset
//   s_flush_i                  pipeline flush, empties the queue
//   s_pred_push_i/taken/add    prediction from fetch; s_pred_full_o stalls it
//   s_exe_*                    resolving instruction (valid = queue pop)
//   s_branch_*/s_btb_update_o  registered predictor update
//   s_ualigc_o                 RVC branch at a halfword-odd address
//   s_invalidate_o             stale BTB hit on a non-branch
//   s_redirect_o/_add_o        misprediction redirect and correct fetch address
//   s_mispred_cnt_o            saturating misprediction count
module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             s_clk_i,
    input  logic             s_resetn_i,
    input  logic             s_flush_i,
    input  logic             s_pred_push_i,
    input  logic             s_pred_taken_i,
    input  logic [31:0]      s_pred_add_i,
    output logic             s_pred_full_o,
    input  logic             s_exe_valid_i,
    input  logic             s_exe_branch_i,
    input  logic             s_exe_taken_i,
    input  logic [31:0]      s_exe_pc_i,
    input  logic [31:0]      s_exe_target_i,
    input  logic [11:0]      s_exe_offset_i,
    input  logic             s_exe_rvc_i,
    output logic             s_branch_update_o,
    output logic             s_branch_taken_o,
    output logic             s_btb_update_o,
    output logic             s_ualigc_o,
    output logic [11:0]      s_branch_offset_o,
    output logic [31:0]      s_branch_add_o,
    output logic             s_invalidate_o,
    output logic             s_redirect_o,
    output logic [31:0]      s_redirect_add_o,
    output logic [CNT_W-1:0] s_mispred_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          taken_mem  [DEPTH];
    logic [31:0]   target_mem [DEPTH];

    logic          empty, full, pop, push_ok;
    logic          head_taken;
    logic [31:0]   head_target;
    logic          actual, mispred;
    logic [31:0]   seq;

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        // Extra pointer bit distinguishes full from empty.
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop     = s_exe_valid_i && !empty;
        // A pop frees a slot in the same cycle, so push while full is fine then.
        push_ok = s_pred_push_i && (!full || pop);
        // Pop on empty sees "not taken"; a same-cycle push is never bypassed.
        head_taken  = !empty && taken_mem[rd_ptr[AW-1:0]];
        head_target = target_mem[rd_ptr[AW-1:0]];
        actual  = s_exe_branch_i && s_exe_taken_i;
        mispred = s_exe_valid_i &&
                  ((head_taken != actual) ||
                   (head_taken && actual && (head_target != s_exe_target_i)));
        seq     = s_exe_pc_i + (s_exe_rvc_i ? 32'd2 : 32'd4);
    end

    assign s_pred_full_o = full;

    // Queue storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge s_clk_i) begin
        if (push_ok) begin
            taken_mem[wr_ptr[AW-1:0]]  <= s_pred_taken_i;
            target_mem[wr_ptr[AW-1:0]] <= s_pred_add_i;
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (mispred || s_flush_i) begin
            // Everything still queued belongs to the wrong path.
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            s_branch_update_o <= 1'b0;
            s_btb_update_o    <= 1'b0;
            s_invalidate_o    <= 1'b0;
            s_redirect_o      <= 1'b0;
            s_branch_taken_o  <= 1'b0;
            s_ualigc_o        <= 1'b0;
            s_branch_offset_o <= '0;
            s_branch_add_o    <= '0;
            s_redirect_add_o  <= '0;
            s_mispred_cnt_o   <= '0;
        end else begin
            s_branch_update_o <= s_exe_valid_i && s_exe_branch_i;
            s_btb_update_o    <= s_exe_valid_i && actual;
            s_invalidate_o    <= s_exe_valid_i && head_taken && !s_exe_branch_i;
            s_redirect_o      <= mispred;
            // Data fields follow the last resolve and hold otherwise.
            if (s_exe_valid_i) begin
                s_branch_taken_o  <= s_exe_taken_i;
                s_ualigc_o        <= s_exe_rvc_i && s_exe_pc_i[1];
                s_branch_offset_o <= s_exe_offset_i;
                s_branch_add_o    <= s_exe_pc_i;
                s_redirect_add_o  <= actual ? s_exe_target_i : seq;
            end
            if (mispred && (s_mispred_cnt_o != {CNT_W{1'b1}}))
                s_mispred_cnt_o <= s_mispred_cnt_o + CNT_W'(1);
        end
    end

endmodule
